// File: rtl/mult_fu.sv
// Four-stage pipelined 64x64 -> low-64 unsigned multiplier feeding the CDB.
// Each stage folds in one 16-bit digit of the multiplier; S4 holds the finished product.
module mult_fu #(
    parameter int unsigned PRF_IDX = 6,
    parameter int unsigned ROB_IDX = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic [63:0]        opa,
    input  logic [63:0]        opb,
    input  logic [PRF_IDX-1:0] pdest_idx,
    input  logic [ROB_IDX-1:0] rob_idx,
    input  logic               flush,
    input  logic               cdb_gnt,
    output logic               mult_free,
    output logic               cdb_req,
    output logic [63:0]        result,
    output logic [PRF_IDX-1:0] pdest_out,
    output logic [ROB_IDX-1:0] rob_idx_out
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned DIG  = 16;
    localparam int unsigned NSTG = 4;
    localparam int unsigned MW   = XLEN - DIG;

    logic               valid_q  [NSTG];
    logic               valid_d  [NSTG];
    logic [PRF_IDX-1:0] pdest_q  [NSTG];
    logic [PRF_IDX-1:0] pdest_d  [NSTG];
    logic [ROB_IDX-1:0] rob_q    [NSTG];
    logic [ROB_IDX-1:0] rob_d    [NSTG];
    logic [XLEN-1:0]    prod_q   [NSTG];
    logic [XLEN-1:0]    prod_d   [NSTG];
    logic [XLEN-1:0]    mcand_q  [NSTG];
    logic [XLEN-1:0]    mcand_d  [NSTG];
    logic [MW-1:0]      mplier_q [NSTG];
    logic [MW-1:0]      mplier_d [NSTG];

    logic stall;

    // A waiting result that the CDB has not taken freezes the whole pipe
    assign stall       = valid_q[NSTG-1] & ~cdb_gnt;
    assign mult_free   = ~stall;
    assign cdb_req     = valid_q[NSTG-1];
    assign result      = prod_q[NSTG-1];
    assign pdest_out   = pdest_q[NSTG-1];
    assign rob_idx_out = rob_q[NSTG-1];

    // Next-state: advance unless stalled; stage k adds digit k of the multiplier
    always_comb begin
        valid_d  = valid_q;
        pdest_d  = pdest_q;
        rob_d    = rob_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;

        if (!stall) begin
            valid_d[0]  = issue_valid;
            pdest_d[0]  = pdest_idx;
            rob_d[0]    = rob_idx;
            prod_d[0]   = opa * XLEN'(opb[DIG-1:0]);
            mcand_d[0]  = opa;
            mplier_d[0] = opb[XLEN-1:DIG];
            for (int k = 1; k < NSTG; k++) begin
                valid_d[k]  = valid_q[k-1];
                pdest_d[k]  = pdest_q[k-1];
                rob_d[k]    = rob_q[k-1];
                prod_d[k]   = prod_q[k-1]
                            + ((mcand_q[k-1] * XLEN'(mplier_q[k-1][DIG-1:0])) << (DIG * k));
                mcand_d[k]  = mcand_q[k-1];
                mplier_d[k] = mplier_q[k-1] >> DIG;
            end
        end

        // Squash kills everything in flight, stalled or not
        if (flush) begin
            for (int k = 0; k < NSTG; k++) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTG; k++) begin
                valid_q[k]  <= 1'b0;
                pdest_q[k]  <= '0;
                rob_q[k]    <= '0;
                prod_q[k]   <= '0;
                mcand_q[k]  <= '0;
                mplier_q[k] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            pdest_q  <= pdest_d;
            rob_q    <= rob_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: tb/tb_mult_fu.sv
// Scoreboard bench for mult_fu: the driver pushes expected products on accepted
// issues, a negedge monitor pops and compares on every CDB grant.
module tb_mult_fu;

    localparam int unsigned PRF_IDX = 6;
    localparam int unsigned ROB_IDX = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               issue_valid;
    logic [63:0]        opa;
    logic [63:0]        opb;
    logic [PRF_IDX-1:0] pdest_idx;
    logic [ROB_IDX-1:0] rob_idx;
    logic               flush;
    logic               cdb_gnt;
    logic               mult_free;
    logic               cdb_req;
    logic [63:0]        result;
    logic [PRF_IDX-1:0] pdest_out;
    logic [ROB_IDX-1:0] rob_idx_out;

    typedef struct packed {
        logic [63:0]        res;
        logic [PRF_IDX-1:0] pd;
        logic [ROB_IDX-1:0] rb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;

    mult_fu #(.PRF_IDX(PRF_IDX), .ROB_IDX(ROB_IDX)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .opa(opa), .opb(opb),
        .pdest_idx(pdest_idx), .rob_idx(rob_idx), .flush(flush), .cdb_gnt(cdb_gnt),
        .mult_free(mult_free), .cdb_req(cdb_req), .result(result),
        .pdest_out(pdest_out), .rob_idx_out(rob_idx_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit iv, input logic [63:0] a, input logic [63:0] b,
                         input int pd, input int rb, input bit gnt, input bit fl, input bit rst);
        issue_valid = iv;
        opa         = a;
        opb         = b;
        pdest_idx   = PRF_IDX'(pd);
        rob_idx     = ROB_IDX'(rb);
        cdb_gnt     = gnt;
        flush       = fl;
        reset       = rst;
    endtask

    // One clock: decide acceptance from mid-cycle signals, then step past the edge
    task automatic cycle();
        logic [63:0] p;
        @(negedge clk);
        #1;
        if (reset || flush) begin
            sb.delete();
        end else if (issue_valid && mult_free) begin
            p = opa * opb;
            sb.push_back('{res: p, pd: pdest_idx, rb: rob_idx});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_free"},   64'(mult_free),   64'd1);
        check({tag, "_req"},    64'(cdb_req),     64'd0);
        check({tag, "_result"}, result,           64'd0);
        check({tag, "_pdest"},  64'(pdest_out),   64'd0);
        check({tag, "_rob"},    64'(rob_idx_out), 64'd0);
    endtask

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = '1;
            2:       v = 64'd1 << $urandom_range(0, 63);
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Monitor: handshake rule, stability under stall, and in-order scoreboard pop
    initial begin
        bit          hold_v = 1'b0;
        logic [63:0] h_res;
        logic [63:0] h_pd;
        logic [63:0] h_rb;
        exp_t        e;
        while (!done) begin
            @(negedge clk);
            if (done) break;
            check("mult_free_rule", 64'(mult_free), 64'(!(cdb_req && !cdb_gnt)));
            if (cdb_req && hold_v) begin
                check("stall_result", result, h_res);
                check("stall_pdest", 64'(pdest_out), h_pd);
                check("stall_rob", 64'(rob_idx_out), h_rb);
            end
            if (cdb_req && sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_req: got cdb_req=1 expected no op in flight (t=%0t)", $time);
            end else if (cdb_req && cdb_gnt) begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("pdest_out", 64'(pdest_out), 64'(e.pd));
                check("rob_idx_out", 64'(rob_idx_out), 64'(e.rb));
            end
            hold_v = cdb_req && !cdb_gnt && !reset;
            h_res  = result;
            h_pd   = 64'(pdest_out);
            h_rb   = 64'(rob_idx_out);
        end
    end

    initial begin
        bit iv, gnt, fl, rst;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        cycle();
        cycle();
        check_zero("reset");
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        cycle();

        // Single op latency and one-cycle presentation
        for (int j = 0; j < 5; j++) begin
            if (j == 0) drive(1, 64'd3, 64'd5, 7, 2, 1, 0, 0);
            else        drive(0, 0, 0, 0, 0, 1, 0, 0);
            cycle();
            check("single_lat_req", 64'(cdb_req), 64'(j == 3));
            if (j == 3) check("single_result", result, 64'd15);
        end

        // Wide operands, overflow discarded
        drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 11, 4, 1, 0, 0);
        cycle();
        drive(1, 64'h1_0000_0000, 64'h1_0000_0000, 12, 5, 1, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        cycle();
        check("wide_ff_x2", result, 64'hFFFF_FFFF_FFFF_FFFE);
        cycle();
        check("wide_2p32_sq", result, 64'd0);
        for (int j = 0; j < 3; j++) cycle();

        // Back-to-back issues complete on consecutive cycles
        for (int j = 0; j < 8; j++) begin
            if (j < 4) drive(1, rnd_op(), rnd_op(), 20 + j, 8 + j, 1, 0, 0);
            else       drive(0, 0, 0, 0, 0, 1, 0, 0);
            cycle();
            check("b2b_req", 64'(cdb_req), 64'(j >= 3 && j <= 6));
        end
        check("b2b_drained", 64'(sb.size()), 64'd0);

        // Stall: fill with no grant, hold, then release
        for (int j = 0; j < 4; j++) begin
            drive(1, rnd_op(), rnd_op(), 30 + j, 12 + j, 0, 0, 0);
            cycle();
        end
        for (int j = 0; j < 3; j++) begin
            drive(1, rnd_op(), rnd_op(), 40, 20, 0, 0, 0);
            cycle();
            check("stall_free", 64'(mult_free), 64'd0);
            check("stall_req", 64'(cdb_req), 64'd1);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        for (int j = 0; j < 6; j++) cycle();
        check("stall_drained", 64'(sb.size()), 64'd0);

        // Flush: three in flight plus an issue on the flush cycle
        for (int j = 0; j < 3; j++) begin
            drive(1, rnd_op(), rnd_op(), 50 + j, 24 + j, 1, 0, 0);
            cycle();
        end
        drive(1, rnd_op(), rnd_op(), 53, 27, 1, 1, 0);
        cycle();
        check("flush_free", 64'(mult_free), 64'd1);
        for (int j = 0; j < 6; j++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0);
            cycle();
            check("flush_no_req", 64'(cdb_req), 64'd0);
        end
        for (int j = 0; j < 5; j++) begin
            if (j == 0) drive(1, 64'd1234567, 64'd7654321, 60, 30, 1, 0, 0);
            else        drive(0, 0, 0, 0, 0, 1, 0, 0);
            cycle();
            check("post_flush_lat", 64'(cdb_req), 64'(j == 3));
        end

        // Reset while stalled with a result waiting
        for (int j = 0; j < 5; j++) begin
            drive(1, rnd_op(), rnd_op(), 2 + j, 1 + j, 0, 0, 0);
            cycle();
        end
        check("pre_reset_req", 64'(cdb_req), 64'd1);
        drive(1, rnd_op(), rnd_op(), 9, 9, 0, 0, 1);
        cycle();
        check_zero("mid_reset");
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        cycle();
        check("post_reset_req", 64'(cdb_req), 64'd0);

        // Random traffic with occasional flushes and one reset
        for (int i = 0; i < 400; i++) begin
            iv  = $urandom_range(0, 99) < 60;
            gnt = $urandom_range(0, 99) < 70;
            fl  = $urandom_range(0, 99) < 3;
            rst = (i == 200);
            drive(iv, rnd_op(), rnd_op(), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 31)), gnt, fl, rst);
            cycle();
            if (rst) check_zero("rand_reset");
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        for (int j = 0; j < 20 && sb.size() != 0; j++) cycle();
        cycle();
        check("final_drained", 64'(sb.size()), 64'd0);

        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
